// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch PC register plus a small {PC, instr} buffer toward decode,
//               with redirect flush. Optional FETCH_MISALIGN_TRAP_EN enables the
//               misaligned-target fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  fault_o
);

    localparam int unsigned           c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned           c_CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0]    c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_ALIGN_MASK = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_q [FIFO_DEPTH];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_fault;
    logic [DATA_WIDTH-1:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    // Raw target is kept so the faulting address is visible on imem_addr_o.
    assign w_target = redirect_pc_i;
    assign w_fault  = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (redirect_i) begin
            fault_d = |redirect_pc_i[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign w_target = redirect_pc_i & c_ALIGN_MASK;
    assign w_fault  = 1'b0;
`endif

    assign imem_addr_o = pc_q;
    assign valid_o     = (count_q != '0);
    assign pc_o        = buf_pc_q[rd_ptr_q];
    assign instr_o     = buf_instr_q[rd_ptr_q];
    assign fault_o     = w_fault;

    assign w_pop  = valid_o && ready_i;
    assign w_push = !redirect_i && !w_fault && ((count_q < c_FULL) || w_pop);

    // Pointers wrap for free because FIFO_DEPTH is a power of two.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_i) begin
            pc_d     = w_target;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                pc_d     = pc_q + c_PC_STEP;
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer payload needs no reset; it is only observed while valid_o is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= imem_instr_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch: directed scenarios followed
//               by randomized ready/redirect traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fault_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected contents of the decode-facing buffer, oldest first: {pc, instr}.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc    = c_RESET_PC;
    logic        m_fault = 1'b0;

    instr_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_instr_i = imem_word(imem_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour at each rising edge: redirect flushes, otherwise a
    // new word is fetched whenever the buffer has room after this cycle's pop.
    task automatic model_edge();
        if (redirect_i) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc    = redirect_pc_i;
            m_fault = (redirect_pc_i % 4) != 0;
`else
            m_pc    = redirect_pc_i - (redirect_pc_i % 4);
            m_fault = 1'b0;
`endif
        end else if (!m_fault && exp_q.size() < c_DEPTH) begin
            exp_q.push_back({m_pc, imem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic monitor_edge();
        logic [63:0] e;
        check("valid", 32'(valid_o), 32'(exp_q.size() != 0));
        check("fetch_addr", imem_addr_o, m_pc);
        check("fault", 32'(fault_o), 32'(m_fault));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("head_pc", pc_o, e[63:32]);
            check("head_instr", instr_o, e[31:0]);
            if (ready_i && !redirect_i) begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    always @(posedge clk or negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc    = c_RESET_PC;
            m_fault = 1'b0;
            if (clk) begin
                #1;
                check("rst_valid", 32'(valid_o), 32'd0);
                check("rst_addr", imem_addr_o, c_RESET_PC);
                check("rst_fault", 32'(fault_o), 32'd0);
            end
        end else if (clk) begin
            model_edge();
        end else begin
            monitor_edge();
        end
    end

    task automatic drive(input logic r, input logic rd, input logic [31:0] t, input int n);
        for (int i = 0; i < n; i++) begin
            ready_i       = r;
            redirect_i    = rd;
            redirect_pc_i = t;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 6);

        // Stall after a fresh reset so the buffer saturates, then drain.
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 5);
        drive(1'b1, 1'b0, 32'd0, 6);

        // Redirect with a full buffer.
        drive(1'b0, 1'b0, 32'd0, 3);
        drive(1'b1, 1'b1, 32'h0000_0040, 1);
        drive(1'b1, 1'b0, 32'd0, 4);

        // Address wrap past 0xFFFF_FFFC.
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        drive(1'b1, 1'b0, 32'd0, 5);

        // Misaligned target, then aligned recovery.
        drive(1'b1, 1'b1, 32'h0000_0042, 1);
        drive(1'b1, 1'b0, 32'd0, 4);
        drive(1'b1, 1'b1, 32'h0000_0080, 1);
        drive(1'b1, 1'b0, 32'd0, 3);

        // Back-to-back redirects: the last one wins.
        drive(1'b1, 1'b1, 32'h0000_0100, 1);
        drive(1'b1, 1'b1, 32'h0000_0200, 1);
        drive(1'b1, 1'b0, 32'd0, 4);

        // Asynchronous reset asserted between clock edges.
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'd0, 2);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 4);

        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       t = $urandom & 32'hFFFF_FFFC;
                default: t = $urandom;
            endcase
            drive(r, rd, t, 1);
        end

        drive(1'b1, 1'b1, 32'h0000_0300, 1);
        drive(1'b1, 1'b0, 32'd0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
